// File: rtl/ifetch_ctrl.sv
// ============================================================================
// ifetch_ctrl
// ----------------------------------------------------------------------------
// Instruction-fetch controller sitting between the pre-IF PC generator and the
// IF/ID boundary.  It keeps at most one request outstanding on the CPU
// instruction bus.  The bus uses two separate handshakes: one to accept the
// address and one to return the data.  The returned instruction is buffered
// until ID accepts it.  A pipeline flush cancels any fetch that is in flight.
// If pre-IF reports a TLB fetch exception, no bus request is made; the
// exception travels down the pipe with a zero instruction instead.
//
// Parameters
//   EXC_W          width of the TLB exception code (0 none, 1 refill, 2 invalid)
//
// Ports
//   clk            system clock
//   resetn         synchronous, active-low reset
//   preif_pc       PC to fetch; held by pre-IF until preif_ready
//   preif_exc      TLB exception code for preif_pc
//   preif_ready    1-cycle pulse: preif_pc consumed, pre-IF may advance
//   flush          pipeline flush / redirect
//   id_allowin     ID can take the IF instruction this cycle
//   ibus_req       instruction-bus request valid
//   ibus_addr      request address (combinational copy of preif_pc)
//   ibus_addr_ok   bus accepted the request this cycle
//   ibus_data_ok   read data valid this cycle
//   ibus_rdata     read data
//   if_valid       IF holds a valid instruction for ID
//   if_pc          PC of the buffered instruction
//   if_instr       buffered instruction
//   if_exc         exception code of the buffered instruction
//   if_busy        a fetch is pending on the bus (REQ, WAIT, CANCEL)
// ============================================================================
module ifetch_ctrl #(
    parameter int EXC_W = 2
) (
    input  logic             clk,
    input  logic             resetn,

    input  logic [31:0]      preif_pc,
    input  logic [EXC_W-1:0] preif_exc,
    output logic             preif_ready,

    input  logic             flush,
    input  logic             id_allowin,

    output logic             ibus_req,
    output logic [31:0]      ibus_addr,
    input  logic             ibus_addr_ok,
    input  logic             ibus_data_ok,
    input  logic [31:0]      ibus_rdata,

    output logic             if_valid,
    output logic [31:0]      if_pc,
    output logic [31:0]      if_instr,
    output logic [EXC_W-1:0] if_exc,
    output logic             if_busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_HOLD   = 3'd3,
        ST_CANCEL = 3'd4
    } state_t;

    localparam logic [EXC_W-1:0] EXC_NONE = '0;

    // ------------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------------
    state_t           state_q,    state_d;
    logic [31:0]      pend_pc_q,  pend_pc_d;   // PC of the accepted request
    logic [31:0]      if_pc_q,    if_pc_d;
    logic [31:0]      if_instr_q, if_instr_d;
    logic [EXC_W-1:0] if_exc_q,   if_exc_d;
    logic             if_valid_q, if_valid_d;
    logic             if_busy_q,  if_busy_d;

    logic             exc_none;
    logic             handshake;

    assign exc_none  = (preif_exc == EXC_NONE);
    // The request is only raised in REQ and only without an exception, so
    // gating addr_ok with ibus_req is enough to detect a real handshake.
    assign handshake = ibus_req && ibus_addr_ok;
    assign ibus_addr = preif_pc;

    // ------------------------------------------------------------------------
    // Next-state, buffer-load and combinational handshake outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pend_pc_d   = pend_pc_q;
        if_pc_d     = if_pc_q;
        if_instr_d  = if_instr_q;
        if_exc_d    = if_exc_q;
        ibus_req    = 1'b0;
        preif_ready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end

            ST_REQ: begin
                ibus_req = exc_none;
                if (!exc_none) begin
                    // Exception bypass: no bus access, deliver the exception
                    // with a zero instruction.  A flush holds us here so the
                    // redirected PC is examined next cycle instead.
                    if (!flush) begin
                        preif_ready = 1'b1;
                        if_pc_d     = preif_pc;
                        if_instr_d  = 32'h0;
                        if_exc_d    = preif_exc;
                        state_d     = ST_HOLD;
                    end
                end else if (handshake) begin
                    // The bus now owes us one response even if we are being
                    // flushed; CANCEL exists to swallow it.
                    preif_ready = 1'b1;
                    pend_pc_d   = preif_pc;
                    state_d     = flush ? ST_CANCEL : ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (ibus_data_ok) begin
                    if (flush) begin
                        state_d = ST_REQ;
                    end else begin
                        if_pc_d    = pend_pc_q;
                        if_instr_d = ibus_rdata;
                        if_exc_d   = EXC_NONE;
                        state_d    = ST_HOLD;
                    end
                end else if (flush) begin
                    state_d = ST_CANCEL;
                end
            end

            ST_CANCEL: begin
                // Exactly one orphaned response is outstanding; further
                // flushes do not change that count.
                if (ibus_data_ok) begin
                    state_d = ST_REQ;
                end
            end

            ST_HOLD: begin
                if (flush || id_allowin) begin
                    state_d = ST_REQ;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they line up
        // exactly with the state they describe.
        if_valid_d = (state_d == ST_HOLD);
        if_busy_d  = (state_d == ST_REQ) || (state_d == ST_WAIT) ||
                     (state_d == ST_CANCEL);
    end

    // ------------------------------------------------------------------------
    // Flops
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            pend_pc_q  <= 32'h0;
            if_pc_q    <= 32'h0;
            if_instr_q <= 32'h0;
            if_exc_q   <= EXC_NONE;
            if_valid_q <= 1'b0;
            if_busy_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_pc_q  <= pend_pc_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            if_exc_q   <= if_exc_d;
            if_valid_q <= if_valid_d;
            if_busy_q  <= if_busy_d;
        end
    end

    assign if_valid = if_valid_q;
    assign if_pc    = if_pc_q;
    assign if_instr = if_instr_q;
    assign if_exc   = if_exc_q;
    assign if_busy  = if_busy_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed testbench for ifetch_ctrl.  The bench plays both pre-IF and the
// instruction bus cycle by cycle.  Inputs are driven 1 time unit after the
// rising edge and outputs are checked 1 unit later.
module tb_ifetch_ctrl;

    localparam int EXC_W = 2;

    logic             clk = 1'b0;
    logic             resetn;
    logic [31:0]      preif_pc;
    logic [EXC_W-1:0] preif_exc;
    logic             preif_ready;
    logic             flush;
    logic             id_allowin;
    logic             ibus_req;
    logic [31:0]      ibus_addr;
    logic             ibus_addr_ok;
    logic             ibus_data_ok;
    logic [31:0]      ibus_rdata;
    logic             if_valid;
    logic [31:0]      if_pc;
    logic [31:0]      if_instr;
    logic [EXC_W-1:0] if_exc;
    logic             if_busy;

    int errors = 0;
    int checks = 0;

    ifetch_ctrl #(.EXC_W(EXC_W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .preif_pc     (preif_pc),
        .preif_exc    (preif_exc),
        .preif_ready  (preif_ready),
        .flush        (flush),
        .id_allowin   (id_allowin),
        .ibus_req     (ibus_req),
        .ibus_addr    (ibus_addr),
        .ibus_addr_ok (ibus_addr_ok),
        .ibus_data_ok (ibus_data_ok),
        .ibus_rdata   (ibus_rdata),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .if_exc       (if_exc),
        .if_busy      (if_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to the next cycle: edge, then a small offset for driving.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".if_valid"},    {31'b0, if_valid},    32'd0);
        check({tag, ".ibus_req"},    {31'b0, ibus_req},    32'd0);
        check({tag, ".preif_ready"}, {31'b0, preif_ready}, 32'd0);
        check({tag, ".if_busy"},     {31'b0, if_busy},     32'd0);
        check({tag, ".if_pc"},       if_pc,                32'h0);
        check({tag, ".if_instr"},    if_instr,             32'h0);
        check({tag, ".if_exc"},      {30'b0, if_exc},      32'd0);
    endtask

    // One line per bus transaction or delivered instruction.
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (ibus_req && ibus_addr_ok)
                $display("bus req  addr=%h", ibus_addr);
            if (ibus_data_ok)
                $display("bus data rdata=%h", ibus_rdata);
            if (if_valid && (id_allowin || flush))
                $display("if out   pc=%h instr=%h exc=%0d flush=%0b",
                         if_pc, if_instr, if_exc, flush);
        end
    end

    initial begin
        resetn       = 1'b0;
        preif_pc     = 32'hBFC0_0000;
        preif_exc    = '0;
        flush        = 1'b0;
        id_allowin   = 1'b1;
        ibus_addr_ok = 1'b0;
        ibus_data_ok = 1'b0;
        ibus_rdata   = 32'h0;

        // ---------------- reset ----------------
        repeat (3) next_cycle();
        settle();
        check_reset_outputs("rst");

        // ---------------- reset and first fetch ----------------
        resetn = 1'b1;                       // cycle 1: IDLE
        settle();
        check("c1.ibus_req", {31'b0, ibus_req}, 32'd0);
        next_cycle();                        // cycle 2: REQ
        ibus_addr_ok = 1'b1;
        settle();
        check("c2.ibus_req",    {31'b0, ibus_req},    32'd1);
        check("c2.preif_ready", {31'b0, preif_ready}, 32'd1);
        check("c2.ibus_addr",   ibus_addr,            32'hBFC0_0000);
        next_cycle();                        // cycle 3: WAIT
        ibus_addr_ok = 1'b0;
        preif_pc     = 32'hBFC0_0004;
        ibus_data_ok = 1'b1;
        ibus_rdata   = 32'h2402_0001;
        settle();
        check("c3.ibus_req", {31'b0, ibus_req}, 32'd0);
        check("c3.if_valid", {31'b0, if_valid}, 32'd0);
        check("c3.if_busy",  {31'b0, if_busy},  32'd1);
        next_cycle();                        // cycle 4: HOLD

        // ---------------- ID stall ----------------
        ibus_data_ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            id_allowin = 1'b0;
            settle();
            check("stall.if_valid", {31'b0, if_valid}, 32'd1);
            check("stall.if_pc",    if_pc,             32'hBFC0_0000);
            check("stall.if_instr", if_instr,          32'h2402_0001);
            check("stall.ibus_req", {31'b0, ibus_req}, 32'd0);
            if (i == 0) begin
                check("c4.if_exc",  {30'b0, if_exc},   32'd0);
                check("c4.if_busy", {31'b0, if_busy},  32'd0);
            end
            next_cycle();
        end
        id_allowin = 1'b1;                   // ID takes it this edge
        settle();
        check("release.if_valid", {31'b0, if_valid}, 32'd1);
        next_cycle();                        // REQ
        settle();
        check("release.ibus_req",  {31'b0, ibus_req}, 32'd1);
        check("release.ibus_addr", ibus_addr,         32'hBFC0_0004);
        check("release.if_valid",  {31'b0, if_valid}, 32'd0);

        // ---------------- flush during WAIT ----------------
        ibus_addr_ok = 1'b1;                 // handshake for BFC0_0004
        settle();
        next_cycle();                        // WAIT
        ibus_addr_ok = 1'b0;
        flush        = 1'b1;
        preif_pc     = 32'h8000_0180;
        settle();
        check("fw.busy_wait", {31'b0, if_busy}, 32'd1);
        next_cycle();                        // CANCEL
        flush = 1'b0;
        settle();
        check("fw.cancel_busy",  {31'b0, if_busy},  32'd1);
        check("fw.cancel_req",   {31'b0, ibus_req}, 32'd0);
        check("fw.cancel_valid", {31'b0, if_valid}, 32'd0);
        next_cycle();                        // CANCEL, extra flush
        flush = 1'b1;
        settle();
        check("fw.cancel2_req", {31'b0, ibus_req}, 32'd0);
        next_cycle();                        // stale response
        flush        = 1'b0;
        ibus_data_ok = 1'b1;
        ibus_rdata   = 32'hDEAD_BEEF;
        settle();
        check("fw.stale_valid", {31'b0, if_valid}, 32'd0);
        next_cycle();                        // REQ
        ibus_data_ok = 1'b0;
        settle();
        check("fw.redirect_req",  {31'b0, ibus_req}, 32'd1);
        check("fw.redirect_addr", ibus_addr,         32'h8000_0180);
        check("fw.no_deadbeef",   if_instr,          32'h2402_0001);
        check("fw.after_valid",   {31'b0, if_valid}, 32'd0);

        // ---------------- flush with addr_ok, then data_ok with flush -----
        ibus_addr_ok = 1'b1;
        flush        = 1'b1;
        settle();
        check("fa.preif_ready", {31'b0, preif_ready}, 32'd1);
        next_cycle();                        // CANCEL
        ibus_addr_ok = 1'b0;
        flush        = 1'b0;
        settle();
        check("fa.cancel_req",  {31'b0, ibus_req}, 32'd0);
        check("fa.cancel_busy", {31'b0, if_busy},  32'd1);
        next_cycle();                        // orphan response
        ibus_data_ok = 1'b1;
        ibus_rdata   = 32'h0BAD_0001;
        settle();
        check("fa.orphan_valid", {31'b0, if_valid}, 32'd0);
        next_cycle();                        // REQ
        ibus_data_ok = 1'b0;
        settle();
        check("fa.fresh_req", {31'b0, ibus_req}, 32'd1);
        ibus_addr_ok = 1'b1;
        next_cycle();                        // WAIT
        ibus_addr_ok = 1'b0;
        ibus_data_ok = 1'b1;
        ibus_rdata   = 32'h0BAD_0002;
        flush        = 1'b1;
        preif_pc     = 32'h8000_0200;
        settle();
        check("fd.wait_valid", {31'b0, if_valid}, 32'd0);
        next_cycle();                        // REQ
        ibus_data_ok = 1'b0;
        flush        = 1'b0;
        settle();
        check("fd.fresh_req",  {31'b0, ibus_req}, 32'd1);
        check("fd.fresh_addr", ibus_addr,         32'h8000_0200);
        check("fd.valid",      {31'b0, if_valid}, 32'd0);
        check("fd.instr_kept", if_instr,          32'h2402_0001);

        // ---------------- TLB refill ----------------
        next_cycle();                        // still REQ (no addr_ok)
        preif_exc = 2'd1;
        preif_pc  = 32'h0040_0000;
        flush     = 1'b1;                    // exception + flush: stay
        settle();
        check("tlb.flush_ready", {31'b0, preif_ready}, 32'd0);
        check("tlb.flush_req",   {31'b0, ibus_req},    32'd0);
        next_cycle();
        flush = 1'b0;
        settle();
        check("tlb.req",   {31'b0, ibus_req},    32'd0);
        check("tlb.ready", {31'b0, preif_ready}, 32'd1);
        next_cycle();                        // HOLD
        preif_exc  = '0;
        preif_pc   = 32'hBFC0_0100;
        id_allowin = 1'b0;
        flush      = 1'b1;                   // flush drops the buffer
        settle();
        check("tlb.if_valid", {31'b0, if_valid}, 32'd1);
        check("tlb.if_exc",   {30'b0, if_exc},   32'd1);
        check("tlb.if_instr", if_instr,          32'h0);
        check("tlb.if_pc",    if_pc,             32'h0040_0000);
        next_cycle();                        // REQ
        flush      = 1'b0;
        id_allowin = 1'b1;
        settle();
        check("hflush.valid", {31'b0, if_valid}, 32'd0);
        check("hflush.req",   {31'b0, ibus_req}, 32'd1);

        // ---------------- reset mid-WAIT ----------------
        ibus_addr_ok = 1'b1;
        next_cycle();                        // WAIT
        ibus_addr_ok = 1'b0;
        resetn       = 1'b0;
        settle();
        check("rw.busy", {31'b0, if_busy}, 32'd1);
        next_cycle();                        // IDLE after reset
        resetn       = 1'b1;
        ibus_data_ok = 1'b1;                 // late response, ignored
        ibus_rdata   = 32'hDEAD_BEEF;
        settle();
        check_reset_outputs("rw");
        next_cycle();                        // REQ
        ibus_data_ok = 1'b0;
        ibus_addr_ok = 1'b1;
        settle();
        check("rw.req",   {31'b0, ibus_req}, 32'd1);
        check("rw.addr",  ibus_addr,         32'hBFC0_0100);
        check("rw.valid", {31'b0, if_valid}, 32'd0);
        next_cycle();                        // WAIT
        ibus_addr_ok = 1'b0;
        ibus_data_ok = 1'b1;
        ibus_rdata   = 32'h3C1D_0000;
        settle();
        check("rw.wait_valid", {31'b0, if_valid}, 32'd0);
        next_cycle();                        // HOLD
        ibus_data_ok = 1'b0;
        settle();
        check("rw.if_valid", {31'b0, if_valid}, 32'd1);
        check("rw.if_pc",    if_pc,             32'hBFC0_0100);
        check("rw.if_instr", if_instr,          32'h3C1D_0000);
        check("rw.if_exc",   {30'b0, if_exc},   32'd0);

        next_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
